// File: rtl/execute_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
//   mdu_op_t    : operation encoding presented on the request interface
//   mdu_state_e : control FSM states
//   mdu_cnt_w() : iteration counter width for a given operand width
//   MDU_CNT_W   : counter width at the default 64-bit operand width
package execute_mdu_pkg;

    typedef enum logic [2:0] {
        OpMul    = 3'd0,
        OpMulh   = 3'd1,
        OpMulhsu = 3'd2,
        OpMulhu  = 3'd3,
        OpDiv    = 3'd4,
        OpDivu   = 3'd5,
        OpRem    = 3'd6,
        OpRemu   = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } mdu_state_e;

    // Counter must hold the value XLEN itself, hence the extra bit.
    function automatic int unsigned mdu_cnt_w(input int unsigned xlen);
        return $clog2(xlen) + 1;
    endfunction

    localparam int unsigned MDU_XLEN_DEF = 64;
    localparam int unsigned MDU_CNT_W    = mdu_cnt_w(MDU_XLEN_DEF);

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step on unsigned magnitudes.
//   rem_i     : partial remainder entering the step
//   bit_i     : next dividend bit shifted into the remainder
//   divisor_i : divisor magnitude
//   rem_o     : partial remainder leaving the step
//   q_o       : quotient bit produced by the step
module mdu_divstep #(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);

    logic [XLEN:0] shifted;

    always_comb begin
        shifted = {rem_i, bit_i};
        q_o     = (shifted >= {1'b0, divisor_i});
        // The restored remainder is always below the divisor, so it fits in XLEN bits.
        rem_o   = q_o ? (shifted[XLEN-1:0] - divisor_i) : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/execute_mdu.sv
// Iterative multiply/divide unit for the execute stage (one radix-2 step per cycle).
//   clk, reset          : clock and asynchronous active-low reset
//   in_valid/in_ready   : request handshake carrying op, word, a, b
//   op, word, a, b      : operation, word-mode flag, operands
//   flush               : kills any in-flight or completed operation
//   out_valid/out_ready : result handshake
//   result              : operation result, zero when out_valid is low
//   busy                : unit is not idle
module execute_mdu
    import execute_mdu_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned WORD_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  mdu_op_t         op,
    input  logic            word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned CntW = mdu_cnt_w(XLEN);
    localparam int unsigned Sh   = XLEN - WORD_W;
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
        return $signed(x << Sh) >>> Sh;
    endfunction

    function automatic logic [XLEN-1:0] zext_w(input logic [XLEN-1:0] x);
        return (x << Sh) >> Sh;
    endfunction

    function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] x, input logic w);
        return w ? sext_w(x) : x;
    endfunction

    mdu_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    mdu_op_t         op_q, op_d;
    logic            word_q, word_d;
    logic [XLEN-1:0] acc_q, acc_d;   // product high half / partial remainder
    logic [XLEN-1:0] mq_q, mq_d;     // multiplier+product low half / dividend+quotient
    logic [XLEN-1:0] opb_q, opb_d;   // multiplicand / divisor magnitude
    logic            neg_q, neg_d;   // negate product or quotient
    logic            rneg_q, rneg_d; // negate remainder
    logic [XLEN-1:0] res_q, res_d;

    // Request decode, evaluated at the effective operand width.
    logic            req_word, req_div, sgn_a, sgn_b, neg_a, neg_b;
    logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, a_min;
    logic            req_div0, req_ovf, req_special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        req_word = word && !(op inside {OpMulh, OpMulhsu, OpMulhu});
        req_div  = op inside {OpDiv, OpDivu, OpRem, OpRemu};
        sgn_a    = op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
        sgn_b    = op inside {OpMulh, OpDiv, OpRem};
        a_ext    = req_word ? (sgn_a ? sext_w(a) : zext_w(a)) : a;
        b_ext    = req_word ? (sgn_b ? sext_w(b) : zext_w(b)) : b;
        neg_a    = sgn_a && a_ext[XLEN-1];
        neg_b    = sgn_b && b_ext[XLEN-1];
        mag_a    = neg_a ? -a_ext : a_ext;
        mag_b    = neg_b ? -b_ext : b_ext;
        a_min    = req_word ? sext_w(MinNeg >> Sh) : MinNeg;

        req_div0    = req_div && (b_ext == '0);
        req_ovf     = req_div && sgn_b && (a_ext == a_min) && (b_ext == '1);
        req_special = req_div0 || req_ovf;

        special_res = '0;
        if (req_div0) begin
            special_res = (op inside {OpDiv, OpDivu}) ? '1 : fmt(a_ext, req_word);
        end else if (req_ovf && (op == OpDiv)) begin
            special_res = fmt(a_ext, req_word);
        end
    end

    // Datapath step for the operation held in the registers.
    logic            is_div_q;
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] div_rem;
    logic            div_q;
    logic [XLEN-1:0] step_acc, step_mq, mul_hi, final_res;

    mdu_divstep #(
        .XLEN(XLEN)
    ) u_divstep (
        .rem_i    (acc_q),
        .bit_i    (mq_q[XLEN-1]),
        .divisor_i(opb_q),
        .rem_o    (div_rem),
        .q_o      (div_q)
    );

    always_comb begin
        is_div_q = op_q inside {OpDiv, OpDivu, OpRem, OpRemu};
        mul_sum  = mq_q[0] ? ({1'b0, acc_q} + {1'b0, opb_q}) : {1'b0, acc_q};
        if (is_div_q) begin
            step_acc = div_rem;
            step_mq  = {mq_q[XLEN-2:0], div_q};
        end else begin
            step_acc = mul_sum[XLEN:1];
            step_mq  = {mul_sum[0], mq_q[XLEN-1:1]};
        end

        // High half of the negated 2*XLEN product: ~hi plus the carry out of -lo.
        mul_hi = neg_q ? (~step_acc + XLEN'(step_mq == '0)) : step_acc;

        final_res = '0;
        unique case (op_q)
            // After WORD_W steps the low product bits sit at the top of mq.
            OpMul:                     final_res = word_q ? sext_w(step_mq >> Sh) : step_mq;
            OpMulh, OpMulhsu, OpMulhu: final_res = mul_hi;
            OpDiv, OpDivu:             final_res = fmt(neg_q ? -step_mq : step_mq, word_q);
            OpRem, OpRemu:             final_res = fmt(rneg_q ? -step_acc : step_acc, word_q);
            default:                   final_res = '0;
        endcase
    end

    assign in_ready  = (state_q == StIdle) && !flush;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign result    = out_valid ? res_q : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        word_d  = word_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        opb_d   = opb_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        res_d   = res_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    op_d   = op;
                    word_d = req_word;
                    neg_d  = neg_a ^ neg_b;
                    rneg_d = neg_a;
                    if (req_special) begin
                        state_d = StDone;
                        res_d   = special_res;
                    end else begin
                        state_d = StCalc;
                        cnt_d   = req_word ? CntW'(WORD_W) : CntW'(XLEN);
                        acc_d   = '0;
                        if (req_div) begin
                            // Dividend is consumed MSB first, so align it to the top.
                            mq_d  = req_word ? (mag_a << Sh) : mag_a;
                            opb_d = mag_b;
                        end else begin
                            mq_d  = mag_b;
                            opb_d = mag_a;
                        end
                    end
                end
            end
            StCalc: begin
                acc_d = step_acc;
                mq_d  = step_mq;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                    res_d   = final_res;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                    res_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
            res_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= OpMul;
            word_q  <= 1'b0;
            acc_q   <= '0;
            mq_q    <= '0;
            opb_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            word_q  <= word_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            opb_q   <= opb_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_execute_mdu.sv
module tb_execute_mdu;
    import execute_mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    mdu_op_t     op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    execute_mdu #(
        .XLEN  (64),
        .WORD_W(32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .word     (word),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [63:0] res;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%016h, expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for its result, compare against the queued expectation.
    task automatic run_op(input string tag, input mdu_op_t o, input logic w,
                          input logic [63:0] av, input logic [63:0] bv,
                          input logic [63:0] exp_res, input int exp_lat, input int hold);
        exp_t e;
        exp_t got;
        int   k;
        int   busy_cnt;
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        op        = o;
        word      = w;
        a         = av;
        b         = bv;
        out_ready = (hold == 0);
        e.res = exp_res;
        e.lat = exp_lat;
        e.tag = tag;
        sb_q.push_back(e);
        @(posedge clk);
        k        = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                // Inputs changed after accept must not disturb the operation.
                in_valid = 1'b0;
                op       = OpMulhu;
                word     = ~w;
                a        = ~av;
                b        = av ^ bv;
            end
            if (busy) busy_cnt++;
        end while (!out_valid && k < 200);
        got = sb_q.pop_front();
        chk({got.tag, "_latency"}, 64'(k), 64'(got.lat));
        chk({got.tag, "_result"}, result, got.res);
        chk({got.tag, "_busy_cycles"}, 64'(busy_cnt), 64'(got.lat));
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            chk({got.tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({got.tag, "_hold_result"}, result, got.res);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({got.tag, "_post_valid"}, 64'(out_valid), 64'd0);
        chk({got.tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
        chk({got.tag, "_post_result"}, result, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, finish required");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        op        = OpMul;
        word      = 1'b0;
        a         = '0;
        b         = '0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", result, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        run_op("mul_neg", OpMul, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
               64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
        run_op("divu_w", OpDivu, 1'b1, 64'h0000_0001_0000_0064, 64'd7, 64'd14, 33, 0);
        run_op("rem_neg", OpRem, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
               64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
        run_op("div_by0", OpDiv, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        run_op("div_ovf", OpDiv, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 1, 0);
        run_op("mulhu_hold", OpMulhu, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 65, 5);
        run_op("mulh_neg", OpMulh, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3,
               64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
        run_op("mulh_min", OpMulh, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               64'h4000_0000_0000_0000, 65, 0);
        run_op("mulhsu", OpMulhsu, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
        run_op("mulh_word", OpMulh, 1'b1, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000,
               64'd1, 65, 0);
        run_op("div_neg", OpDiv, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
        run_op("divu_big", OpDivu, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
               64'h7FFF_FFFF_FFFF_FFFF, 65, 0);
        run_op("mul_w", OpMul, 1'b1, 64'hABCD_0000_7FFF_FFFF, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFE, 33, 0);
        run_op("div_w", OpDiv, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
        run_op("remu_w", OpRemu, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd16, 64'd15, 33, 0);
        run_op("rem_w_by0", OpRem, 1'b1, 64'h1234_5678_8000_0001, 64'hFFFF_FFFF_0000_0000,
               64'hFFFF_FFFF_8000_0001, 1, 0);
        run_op("div_w_ovf", OpDiv, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 1, 0);
        run_op("rem_ovf", OpRem, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd0, 1, 0);
        run_op("remu_by0", OpRemu, 1'b0, 64'd100, 64'd0, 64'd100, 1, 0);

        // Flush mid-calculation.
        @(negedge clk);
        in_valid = 1'b1;
        op       = OpDiv;
        word     = 1'b0;
        a        = 64'd100;
        b        = 64'd7;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush_no_result", 64'(seen), 64'd0);

        // Flush coincident with a request in IDLE blocks the accept.
        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        op       = OpMul;
        a        = 64'd3;
        b        = 64'd4;
        #1;
        chk("flush_acc_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        chk("flush_acc_busy", 64'(busy), 64'd0);
        chk("flush_acc_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-calculation.
        @(negedge clk);
        in_valid = 1'b1;
        op       = OpMul;
        a        = 64'd5;
        b        = 64'd6;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        reset = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_result", result, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        chk("arst_no_result", 64'(seen), 64'd0);
        run_op("mul_after_rst", OpMul, 1'b0, 64'd3, 64'd4, 64'd12, 65, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_mdu.md
EXECUTE_MDU -- requirements
Module: execute_mdu

Interface
REQ-001 Parameter XLEN, default 64, operand/result width in bits (even, >= 32).
REQ-002 Parameter WORD_W, default 32, width of word-mode (W-suffix) operations; WORD_W <= XLEN.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 in_valid  input  1  request present on op/word/a/b.
REQ-006 in_ready  output  1  unit can accept a request this cycle.
REQ-007 op  input  mdu_op_t (3)  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-008 word  input  1  word mode: operate on a[WORD_W-1:0], b[WORD_W-1:0]; sign-extend the WORD_W-bit result to XLEN.
REQ-009 a, b  input  XLEN  operands (a = dividend/multiplicand, b = divisor/multiplier).
REQ-010 flush  input  1  synchronous kill of any in-flight or completed operation.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 result  output  XLEN  operation result.
REQ-014 busy  output  1  high whenever state is not IDLE (drives pipeline stall).

Function
REQ-015 FSM states IDLE, CALC, DONE; in_ready = (state == IDLE) and not flush.
REQ-016 Accept on rising edge with in_valid && in_ready; operands, op and word are latched; later input changes have no effect.
REQ-017 IDLE -> CALC on accept, iteration counter loaded with N = WORD_W if word else XLEN.
REQ-018 CALC performs one radix-2 step per cycle (shift-add multiply or restoring divide on magnitudes); counter decrements each cycle; CALC -> DONE on the edge where counter goes 1 -> 0.
REQ-019 Normal latency: out_valid rises exactly N+1 cycles after the accept edge (65 for 64-bit, 33 for word mode).
REQ-020 Special cases bypass CALC (IDLE -> DONE on accept, out_valid the next cycle): divide by zero -> DIV/DIVU quotient all ones, REM/REMU result = dividend; signed overflow (most-negative / -1) -> DIV quotient = dividend, REM = 0; all evaluated at effective width, then sign-extended.
REQ-021 Signed ops use operand magnitudes; sign applied on DONE entry: quotient negative iff signs differ, remainder takes dividend sign, product sign per MULH (s x s) / MULHSU (s x u).
REQ-022 MUL returns low XLEN bits of product; MULH/MULHSU/MULHU return high XLEN bits; word has no effect on MULH, MULHSU, MULHU.
REQ-023 Word-mode results: bit WORD_W-1 replicated into result[XLEN-1:WORD_W].
REQ-024 DONE holds out_valid and result stable until out_valid && out_ready; then -> IDLE on that edge; in_ready high the following cycle (one cycle minimum gap).
REQ-025 flush high at any edge forces IDLE, deasserts out_valid next cycle, discards result; flush overrides accept and out_ready in the same cycle.
REQ-026 result = 0 whenever out_valid = 0.

Reset
REQ-027 While reset = 0: state = IDLE, counter = 0, out_valid = 0, busy = 0, result = 0, internal operand/accumulator registers = 0; in_ready = 1 after reset release.
REQ-028 Reset asserted mid-CALC or in DONE abandons the operation immediately (asynchronously); no result is produced after release.

Structure
REQ-029 mdu_op_t enum and MDU_CNT_W localparam formula (clog2(XLEN)+1) belong in the shared pipes package.
REQ-030 One sub-module, mdu_divstep, implements one combinational restoring-divide step (remainder, quotient bit) at XLEN width; multiply step stays inline.

Verification
REQ-031 MUL a=7, b=-3 (XLEN=64), out_ready=1 -> out_valid at accept+65, result = 0xFFFF_FFFF_FFFF_FFEB, busy high 65 cycles.
REQ-032 DIVU word, a=0x0000_0001_0000_0064, b=7 -> out_valid at accept+33, result = 14; REM a=-100, b=7 -> result = -2.
REQ-033 DIV a=5, b=0 -> result = 0xFFFF_FFFF_FFFF_FFFF at accept+1; DIV a=0x8000_0000_0000_0000, b=-1 -> result = 0x8000_0000_0000_0000 at accept+1.
REQ-034 MULHU a=b=0xFFFF_FFFF_FFFF_FFFF, out_ready low 5 cycles after out_valid -> result = 0xFFFF_FFFF_FFFF_FFFE held stable all 5 cycles; in_ready returns one cycle after handshake.
REQ-035 flush at accept+10 of DIV -> out_valid never rises, in_ready high next cycle; flush coincident with in_valid in IDLE -> no accept.
REQ-036 reset driven low at accept+20 -> outputs at reset values immediately; after release, new MUL 3 x 4 -> result 12 at accept+65.
